// File: rtl/ifu_fetch_queue_if.sv
// rtl/ifu_fetch_queue_if.sv - imem request/response, redirect and decoder handshake bundle for ifu_fetch_queue
`timescale 1ns/1ps
interface ifu_fetch_queue_if #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req_vld;
  logic                  imem_req_rdy;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_vld;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  redirect_vld;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  dec_stall;
  logic                  ifu_vld;
  logic [INST_WIDTH-1:0] ifu_inst;
  logic [ADDR_WIDTH-1:0] ifu_pc;

  modport master (
    output imem_req_vld, imem_req_addr, ifu_vld, ifu_inst, ifu_pc,
    input  imem_req_rdy, imem_rsp_vld, imem_rsp_data, redirect_vld, redirect_pc, dec_stall
  );

  modport slave (
    input  imem_req_vld, imem_req_addr, ifu_vld, ifu_inst, ifu_pc,
    output imem_req_rdy, imem_rsp_vld, imem_rsp_data, redirect_vld, redirect_pc, dec_stall
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - sequential-PC fetch unit with credit-limited imem requests and redirect flush
// Optional same-cycle response bypass to the decoder when IFU_BYPASS_EN is defined.
`timescale 1ns/1ps
module ifu_fetch_queue #(
  parameter int              INST_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH   = 4,
  parameter int              MAX_OUTST  = 4
) (
  input  logic clk,
  input  logic rst,
  ifu_fetch_queue_if.master bus
);
  localparam int FQ_AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW    = $clog2(FQ_DEPTH) + 1;
  localparam int OAW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCW   = $clog2(MAX_OUTST) + 1;
  localparam int SW    = ((CW > OCW) ? CW : OCW) + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [INST_WIDTH-1:0] fq_inst [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0] fq_pc   [FQ_DEPTH];
  logic [FQ_AW-1:0]      fq_rd, fq_wr;
  logic [CW-1:0]         fq_cnt;
  logic [ADDR_WIDTH-1:0] if_pc   [MAX_OUTST];
  logic [OAW-1:0]        if_rd, if_wr;
  logic [OCW-1:0]        outst, outst_next, drop_cnt;

  logic [SW-1:0] credit_sum;
  logic          accept, rsp_keep, bypass, push, pop;

  function automatic logic [OAW-1:0] if_inc(input logic [OAW-1:0] p);
    return (p == OAW'(MAX_OUTST - 1)) ? '0 : p + OAW'(1);
  endfunction

  // fq entries plus in-flight requests never exceed the fq size, so a response always has a slot
  assign credit_sum = SW'(fq_cnt) + SW'(outst);
  assign bus.imem_req_vld  = !rst && (credit_sum < SW'(FQ_DEPTH)) &&
                             (outst < OCW'(MAX_OUTST)) && !bus.redirect_vld;
  assign bus.imem_req_addr = pc;
  assign accept     = bus.imem_req_vld && bus.imem_req_rdy;
  assign outst_next = outst + OCW'(accept) - OCW'(bus.imem_rsp_vld);
  assign rsp_keep   = bus.imem_rsp_vld && (drop_cnt == '0) && !bus.redirect_vld;

`ifdef IFU_BYPASS_EN
  assign bypass = rsp_keep && (fq_cnt == '0) && !bus.dec_stall;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_keep && !bypass;
  assign pop  = (fq_cnt != '0) && !bus.dec_stall && !bus.redirect_vld;

  assign bus.ifu_vld  = pop || bypass;
  assign bus.ifu_inst = bypass ? bus.imem_rsp_data : fq_inst[fq_rd];
  assign bus.ifu_pc   = bypass ? if_pc[if_rd]      : fq_pc[fq_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      fq_rd    <= '0;
      fq_wr    <= '0;
      fq_cnt   <= '0;
      if_rd    <= '0;
      if_wr    <= '0;
      outst    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_inst[i] <= '0;
        fq_pc[i]   <= '0;
      end
      for (int i = 0; i < MAX_OUTST; i++) begin
        if_pc[i] <= '0;
      end
    end else begin
      if (bus.redirect_vld) begin
        pc <= bus.redirect_pc;
      end else if (accept) begin
        pc <= pc + ADDR_WIDTH'(4);
      end

      if (accept) begin
        if_pc[if_wr] <= pc;
        if_wr        <= if_inc(if_wr);
      end
      if (bus.imem_rsp_vld) begin
        if_rd <= if_inc(if_rd);
      end
      outst <= outst_next;

      // every request still unanswered after a redirect belongs to the abandoned stream
      if (bus.redirect_vld) begin
        drop_cnt <= outst_next;
      end else if (bus.imem_rsp_vld && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - OCW'(1);
      end

      if (bus.redirect_vld) begin
        fq_rd  <= '0;
        fq_wr  <= '0;
        fq_cnt <= '0;
      end else begin
        if (push) begin
          fq_inst[fq_wr] <= bus.imem_rsp_data;
          fq_pc[fq_wr]   <= if_pc[if_rd];
          fq_wr          <= fq_wr + FQ_AW'(1);
        end
        if (pop) begin
          fq_rd <= fq_rd + FQ_AW'(1);
        end
        fq_cnt <= fq_cnt + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - scoreboard bench for ifu_fetch_queue with a queue-based stream model
`timescale 1ns/1ps
module tb_ifu_fetch_queue;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFU_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct {
    int          rdy_cyc;
    logic [31:0] addr;
  } mreq_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  ifu_fetch_queue_if #(.INST_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  ifu_fetch_queue #(
    .INST_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RESET_PC),
    .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // memory content is a fixed scramble of the address so every PC has a unique instruction
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          lat_mode = 1;
  int          accepts = 0, delivered = 0;
  int          first_acc_cyc = -1, first_vld_cyc = -1;
  bit          need_first = 0;
  logic [31:0] first_pc = 32'hDEAD_BEEF;
  logic [31:0] last_pc = 32'h1;
  bit          saw_wrap = 0;

  // memory: in order, at most one response per cycle, never stalls
  always @(posedge clk) begin
    #1;
    if (rst || mem_q.size() == 0 || mem_q[0].rdy_cyc > cyc) begin
      bus.imem_rsp_vld  = 1'b0;
      bus.imem_rsp_data = 32'h0;
    end else begin
      bus.imem_rsp_vld  = 1'b1;
      bus.imem_rsp_data = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  end

  // monitor: the expected stream is PC, PC+4, ... from the last reset or redirect
  always @(negedge clk) begin
    logic [31:0] e;
    int          lat;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      model_pc   = RESET_PC;
      need_first = 1;
    end else begin
      if (bus.ifu_vld) begin
        chk(!bus.dec_stall && !bus.redirect_vld, "vld_gating", {30'd0, bus.dec_stall, bus.redirect_vld}, 32'h0);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_delivery", bus.ifu_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk(bus.ifu_pc == e, "ifu_pc", bus.ifu_pc, e);
          chk(bus.ifu_inst == mem_data(e), "ifu_inst", bus.ifu_inst, mem_data(e));
        end
        if (last_pc == 32'hFFFF_FFFC && bus.ifu_pc == 32'h0) saw_wrap = 1;
        last_pc = bus.ifu_pc;
        if (need_first) begin
          first_pc   = bus.ifu_pc;
          need_first = 0;
        end
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        delivered++;
      end
      if (bus.imem_req_vld && bus.imem_req_rdy) begin
        chk(bus.imem_req_addr == model_pc, "req_addr", bus.imem_req_addr, model_pc);
        exp_q.push_back(model_pc);
        lat = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
        mem_q.push_back('{rdy_cyc: cyc + lat, addr: bus.imem_req_addr});
        model_pc = model_pc + 32'd4;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        accepts++;
      end
      if (bus.redirect_vld) begin
        chk(!bus.imem_req_vld, "req_during_redirect", {31'd0, bus.imem_req_vld}, 32'h0);
        exp_q.delete();
        model_pc   = bus.redirect_pc;
        need_first = 1;
      end
      chk(exp_q.size() <= FQ_DEPTH, "credit_overflow", exp_q.size(), FQ_DEPTH);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = pc;
    step(1);
    bus.redirect_vld = 1'b0;
    @(negedge clk);
    chk(!bus.ifu_vld, "vld_after_redirect", {31'd0, bus.ifu_vld}, 32'h0);
  endtask

  initial begin
    int n0, a0, k;
    rst = 1'b1;
    bus.imem_req_rdy = 1'b0;
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.dec_stall    = 1'b0;
    step(3);
    @(negedge clk);
    chk(!bus.imem_req_vld, "rst_req_vld", {31'd0, bus.imem_req_vld}, 32'h0);
    chk(!bus.ifu_vld, "rst_ifu_vld", {31'd0, bus.ifu_vld}, 32'h0);
    chk(bus.ifu_inst == 32'h0, "rst_ifu_inst", bus.ifu_inst, 32'h0);
    chk(bus.ifu_pc == 32'h0, "rst_ifu_pc", bus.ifu_pc, 32'h0);

    // sequential fetch, latency and throughput
    @(posedge clk); #2;
    rst = 1'b0;
    bus.imem_req_rdy = 1'b1;
    step(10);
    chk(first_vld_cyc - first_acc_cyc == EXP_LAT, "first_latency", first_vld_cyc - first_acc_cyc, EXP_LAT);
    chk(first_pc == RESET_PC, "first_pc_after_reset", first_pc, RESET_PC);
    n0 = delivered;
    step(8);
    chk(delivered - n0 == 8, "throughput", delivered - n0, 8);

    // decoder stall fills the queue, requests stop by credit
    bus.dec_stall = 1'b1;
    step(20);
    @(negedge clk);
    chk(exp_q.size() == FQ_DEPTH, "stall_occupancy", exp_q.size(), FQ_DEPTH);
    chk(!bus.imem_req_vld, "stall_req_blocked", {31'd0, bus.imem_req_vld}, 32'h0);
    @(posedge clk); #2;
    bus.dec_stall = 1'b0;
    for (int i = 0; i < FQ_DEPTH; i++) begin
      @(negedge clk);
      chk(bus.ifu_vld, "stall_release_b2b", {31'd0, bus.ifu_vld}, 32'h1);
    end

    // redirect with several responses in flight
    lat_mode = 3;
    step(8);
    redirect(32'h100);
    lat_mode = 1;
    step(10);
    chk(first_pc == 32'h100, "redirect_first_pc", first_pc, 32'h100);

    // redirect landing on a response cycle
    k = 0;
    while (!bus.imem_rsp_vld && k < 50) begin step(1); k++; end
    chk(bus.imem_rsp_vld, "rsp_seen_timeout", {31'd0, bus.imem_rsp_vld}, 32'h1);
    redirect(32'h180);
    step(10);
    chk(first_pc == 32'h180, "redirect_rsp_first_pc", first_pc, 32'h180);

    // back-to-back redirects with responses pending
    lat_mode = 3;
    step(6);
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 32'h200;
    step(1);
    redirect(32'h300);
    step(12);
    chk(first_pc == 32'h300, "b2b_redirect_first_pc", first_pc, 32'h300);

    // asynchronous reset with a partly full queue
    lat_mode = 1;
    bus.dec_stall = 1'b1;
    redirect(32'hFFFF_FFF0);
    a0 = accepts;
    k = 0;
    while (accepts - a0 < 3 && k < 50) begin step(1); k++; end
    chk(accepts - a0 == 3, "fill3_timeout", accepts - a0, 3);
    bus.imem_req_rdy = 1'b0;
    step(4);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk(bus.ifu_inst == 32'h0, "async_rst_inst", bus.ifu_inst, 32'h0);
    chk(bus.ifu_pc == 32'h0, "async_rst_pc", bus.ifu_pc, 32'h0);
    chk(!bus.imem_req_vld, "async_rst_req", {31'd0, bus.imem_req_vld}, 32'h0);
    step(2);
    rst = 1'b0;
    bus.dec_stall = 1'b0;
    bus.imem_req_rdy = 1'b1;
    step(8);
    chk(first_pc == RESET_PC, "restart_pc", first_pc, RESET_PC);

    // PC wraps modulo 2^32
    redirect(32'hFFFF_FFF0);
    step(12);
    chk(saw_wrap, "pc_wrap", {31'd0, saw_wrap}, 32'h1);

    // randomized traffic
    lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_rdy = ($urandom_range(0, 9) < 7);
      bus.dec_stall    = ($urandom_range(0, 3) == 0);
      bus.redirect_vld = ($urandom_range(0, 99) < 3);
      bus.redirect_pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step(1);
    end
    bus.redirect_vld = 1'b0;
    bus.dec_stall    = 1'b0;
    bus.imem_req_rdy = 1'b0;
    step(20);
    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
